ram_static_config: RTL and testbench
====================================

# ram_static_config

Multi-ported register-file style RAM with NUM_WR_PORTS synchronous write ports and NUM_RD_PORTS combinational read ports. Individual ports and the whole array can be statically gated for power-configurable cores. After reset it self-initializes to zero or to an ascending sequence, then raises ramReady_o. It serves as the generic storage primitive for rename tables, free lists and similar structures.

## Interface
- DEPTH, 128, number of entries.
- INDEX, 7, address width; log2(DEPTH).
- WIDTH, 32, data bits per entry.
- NUM_WR_PORTS, 8, write ports; must be a power of two and at most DEPTH.
- NUM_RD_PORTS, 16, read ports.
- WR_PORTS_LOG, 3, log2(NUM_WR_PORTS).
- RESET_VAL, RAM_RESET_ZERO, init mode: RAM_RESET_ZERO or RAM_RESET_SEQ.
- SEQ_START, 0, first value when RESET_VAL = RAM_RESET_SEQ.
- LATCH_BASED_RAM, 0, 1 selects latch storage and 0 selects flop storage; the setting has no functional difference.
- Ports:
  - clk  in  1  clock.
  - reset  in  1  reset, synchronous, active-low.
  - writePortGated_i  in  NUM_WR_PORTS  1 disables the write port.
  - readPortGated_i  in  NUM_RD_PORTS  1 disables the read port.
  - ramGated_i  in  1  1 gates the whole array.
  - addr_i  in  NUM_RD_PORTS x INDEX  read addresses.
  - data_o  out  NUM_RD_PORTS x WIDTH  read data.
  - addrWr_i  in  NUM_WR_PORTS x INDEX  write addresses.
  - dataWr_i  in  NUM_WR_PORTS x WIDTH  write data.
  - wrEn_i  in  NUM_WR_PORTS  write enables.
  - ramReady_o  out  1  initialization complete.

## Operation
- Reads are combinational.
  - data_o[p] = mem[addr_i[p]].
  - data_o[p] = 0 when readPortGated_i[p] or ramGated_i is 1.
- Writes are synchronous.
  - Port w writes mem[addrWr_i[w]] <= dataWr_i[w] at posedge clk.
  - The write occurs only when wrEn_i[w], ~writePortGated_i[w], ~ramGated_i and ramReady_o are all true.
- Several enabled ports may write the same address in one cycle. The highest port index wins.
- There is no write-to-read bypass. A read in the write cycle returns the old value, and the new value is visible after the edge.
- Initialization states:
  - RESET: reset = 0. Counter cleared, ramReady_o = 0.
  - INIT: entered on the first cycle after reset = 1. Each cycle, entries cnt*NUM_WR_PORTS .. cnt*NUM_WR_PORTS+NUM_WR_PORTS-1 are written with 0 (ZERO mode) or SEQ_START+index truncated to WIDTH (SEQ mode). INIT lasts DEPTH/NUM_WR_PORTS cycles.
  - READY: ramReady_o = 1 and remains 1 until reset.
- User writes are ignored until READY; user reads during INIT return undefined data.
- ramGated_i only freezes the contents; they are not cleared. Port gating is static and may change only while ramReady_o = 0 or all ports are idle.

## Timing
- Read latency is 0 cycles (combinational from addr_i and the array).
- Write latency is 1 edge.
- Reset values:
  - ramReady_o = 0.
  - Init counter = 0.
  - data_o follows the array, which is undefined until INIT completes; gated ports read 0.
- With default parameters, ramReady_o rises 16 cycles after the first cycle with reset = 1.
- Reset asserted mid-INIT or in READY returns to RESET at the next edge and restarts full initialization. Contents are not guaranteed until ready again.

## Structure
- Shared package ram_cfg_pkg holds RAM_RESET_ZERO = 0 and RAM_RESET_SEQ = 1 (2-bit encoding).
- Sub-module ram_init_ctrl holds the init FSM, counter and ramReady_o, and produces init write addresses/data for NUM_WR_PORTS lanes. The top level muxes the init lanes onto the write ports during INIT.
- The storage array is selected by LATCH_BASED_RAM through a generate.

## Test plan
1. Reset then release, defaults with ZERO mode:
   - ramReady_o rises after 16 cycles.
   - All 16 read ports at random addresses return 0.
2. SEQ mode, SEQ_START = 5: after ready, read addr 0x7F -> 0x84 and addr 0x00 -> 0x05.
3. Random traffic for at least 10k cycles: 8 random writes/enables and 16 random reads per cycle, checked against a golden array updated at each edge. Every read must match the pre-edge golden value.
4. Ports 2 and 6 write addr 0x10 with 0xAAAA and 0x5555 in the same cycle -> next cycle addr 0x10 reads 0x5555.
5. Gating:
   - writePortGated_i = 0x01 and port 0 writes 0x1234 to addr 3 -> addr 3 is unchanged.
   - readPortGated_i[4] = 1 -> data_o[4] = 0.
   - ramGated_i = 1 -> all writes are dropped and all reads return 0. Contents are intact after ungating.
6. Assert reset mid-INIT at cycle 8, then release -> a full 16-cycle INIT repeats before ramReady_o rises, and all entries are re-initialized.

Source files
------------

// File: rtl/ram_cfg_pkg.sv
// Shared configuration constants for the statically configurable RAM.
// The init-mode encoding is fixed at 2 bits so that more modes can be added later.
package ram_cfg_pkg;

    localparam logic [1:0] RAM_RESET_ZERO = 2'd0;
    localparam logic [1:0] RAM_RESET_SEQ  = 2'd1;

    localparam logic [1:0] INIT_ST_RESET = 2'd0;
    localparam logic [1:0] INIT_ST_INIT  = 2'd1;
    localparam logic [1:0] INIT_ST_READY = 2'd2;

endpackage

// File: rtl/ram_init_ctrl.sv
// Self-initialisation sequencer: sweeps the array NUM_WR_PORTS entries per cycle,
// then holds ready until the next reset.
module ram_init_ctrl
    import ram_cfg_pkg::*;
#(
    parameter int         DEPTH        = 128,
    parameter int         INDEX        = 7,
    parameter int         WIDTH        = 32,
    parameter int         NUM_WR_PORTS = 8,
    parameter int         WR_PORTS_LOG = 3,
    parameter logic [1:0] RESET_VAL    = RAM_RESET_ZERO,
    parameter int         SEQ_START    = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             init_active,
    output logic [INDEX-1:0] init_addr [NUM_WR_PORTS],
    output logic [WIDTH-1:0] init_data [NUM_WR_PORTS],
    output logic             ready
);

    localparam int CNT_W = (INDEX > WR_PORTS_LOG) ? (INDEX - WR_PORTS_LOG) : 1;
    localparam int LAST  = (DEPTH / NUM_WR_PORTS) - 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= INIT_ST_RESET;
            cnt   <= '0;
        end else begin
            case (state)
                INIT_ST_RESET: begin
                    state <= INIT_ST_INIT;
                    cnt   <= '0;
                end
                INIT_ST_INIT: begin
                    if (cnt == CNT_W'(LAST)) begin
                        state <= INIT_ST_READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_ST_READY: state <= INIT_ST_READY;
                default:       state <= INIT_ST_RESET;
            endcase
        end
    end

    assign init_active = (state == INIT_ST_INIT);
    assign ready       = (state == INIT_ST_READY);

    // Lane w covers entry cnt*NUM_WR_PORTS + w; SEQ data wraps to WIDTH bits.
    always_comb begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            init_addr[w] = INDEX'(int'(cnt) * NUM_WR_PORTS + w);
            if (RESET_VAL == RAM_RESET_SEQ) begin
                init_data[w] = WIDTH'(SEQ_START + int'(cnt) * NUM_WR_PORTS + w);
            end else begin
                init_data[w] = '0;
            end
        end
    end

endmodule

// File: rtl/ram_static_config.sv
// Multi-ported register-file RAM with static port/array gating and
// self-initialisation after reset.
module ram_static_config
    import ram_cfg_pkg::*;
#(
    parameter int         DEPTH           = 128,
    parameter int         INDEX           = 7,
    parameter int         WIDTH           = 32,
    parameter int         NUM_WR_PORTS    = 8,
    parameter int         NUM_RD_PORTS    = 16,
    parameter int         WR_PORTS_LOG    = 3,
    parameter logic [1:0] RESET_VAL       = RAM_RESET_ZERO,
    parameter int         SEQ_START       = 0,
    parameter int         LATCH_BASED_RAM = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WR_PORTS-1:0] writePortGated_i,
    input  logic [NUM_RD_PORTS-1:0] readPortGated_i,
    input  logic                    ramGated_i,
    input  logic [INDEX-1:0]        addr_i   [NUM_RD_PORTS],
    output logic [WIDTH-1:0]        data_o   [NUM_RD_PORTS],
    input  logic [INDEX-1:0]        addrWr_i [NUM_WR_PORTS],
    input  logic [WIDTH-1:0]        dataWr_i [NUM_WR_PORTS],
    input  logic [NUM_WR_PORTS-1:0] wrEn_i,
    output logic                    ramReady_o
);

    logic             init_active;
    logic             ready;
    logic [INDEX-1:0] init_addr [NUM_WR_PORTS];
    logic [WIDTH-1:0] init_data [NUM_WR_PORTS];

    logic [NUM_WR_PORTS-1:0] wr_en;
    logic [INDEX-1:0]        wr_addr [NUM_WR_PORTS];
    logic [WIDTH-1:0]        wr_data [NUM_WR_PORTS];

    logic [WIDTH-1:0] mem [DEPTH];

    ram_init_ctrl #(
        .DEPTH        (DEPTH),
        .INDEX        (INDEX),
        .WIDTH        (WIDTH),
        .NUM_WR_PORTS (NUM_WR_PORTS),
        .WR_PORTS_LOG (WR_PORTS_LOG),
        .RESET_VAL    (RESET_VAL),
        .SEQ_START    (SEQ_START)
    ) u_init_ctrl (
        .clk         (clk),
        .reset       (reset),
        .init_active (init_active),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .ready       (ready)
    );

    assign ramReady_o = ready;

    // Init lanes own the write ports until ready; gating never blocks init.
    always_comb begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (init_active) begin
                wr_en[w]   = 1'b1;
                wr_addr[w] = init_addr[w];
                wr_data[w] = init_data[w];
            end else begin
                wr_en[w]   = wrEn_i[w] && !writePortGated_i[w] && !ramGated_i && ready;
                wr_addr[w] = addrWr_i[w];
                wr_data[w] = dataWr_i[w];
            end
        end
    end

    generate
        if (LATCH_BASED_RAM != 0) begin : g_latch
            logic [NUM_WR_PORTS-1:0] wr_en_q;
            logic [INDEX-1:0]        wr_addr_q [NUM_WR_PORTS];
            logic [WIDTH-1:0]        wr_data_q [NUM_WR_PORTS];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_en_q <= '0;
                end else begin
                    wr_en_q <= wr_en;
                end
                for (int w = 0; w < NUM_WR_PORTS; w++) begin
                    wr_addr_q[w] <= wr_addr[w];
                    wr_data_q[w] <= wr_data[w];
                end
            end

            // Requests are captured at the edge and the latches open only while
            // clk is high, so the update lands just after the edge as with flops.
            always_latch begin
                if (clk) begin
                    for (int w = 0; w < NUM_WR_PORTS; w++) begin
                        if (wr_en_q[w]) begin
                            mem[wr_addr_q[w]] <= wr_data_q[w];
                        end
                    end
                end
            end
        end else begin : g_flop
            // Later loop iterations override earlier ones: highest port wins.
            always_ff @(posedge clk) begin
                for (int w = 0; w < NUM_WR_PORTS; w++) begin
                    if (wr_en[w]) begin
                        mem[wr_addr[w]] <= wr_data[w];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (readPortGated_i[p] || ramGated_i) begin
                data_o[p] = '0;
            end else begin
                data_o[p] = mem[addr_i[p]];
            end
        end
    end

endmodule

// File: tb/tb_ram_static_config.sv
// Directed and table-driven bench for ram_static_config: a ZERO-mode instance
// with a golden array and a SEQ-mode (SEQ_START = 5) instance sharing its inputs.
module tb_ram_static_config;
    import ram_cfg_pkg::*;

    localparam int DEPTH = 128;
    localparam int INDEX = 7;
    localparam int WIDTH = 32;
    localparam int NWR   = 8;
    localparam int NRD   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NWR-1:0]   writePortGated;
    logic [NRD-1:0]   readPortGated;
    logic             ramGated;
    logic [INDEX-1:0] addr    [NRD];
    logic [WIDTH-1:0] data0   [NRD];
    logic [WIDTH-1:0] data1   [NRD];
    logic [INDEX-1:0] addrWr  [NWR];
    logic [WIDTH-1:0] dataWr  [NWR];
    logic [NWR-1:0]   wrEn;
    logic             ready0;
    logic             ready1;

    logic [WIDTH-1:0] gold [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_static_config #(.RESET_VAL(RAM_RESET_ZERO)) dut_zero (
        .clk(clk), .reset(reset), .writePortGated_i(writePortGated),
        .readPortGated_i(readPortGated), .ramGated_i(ramGated), .addr_i(addr),
        .data_o(data0), .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn),
        .ramReady_o(ready0)
    );

    ram_static_config #(.RESET_VAL(RAM_RESET_SEQ), .SEQ_START(5)) dut_seq (
        .clk(clk), .reset(reset), .writePortGated_i(writePortGated),
        .readPortGated_i(readPortGated), .ramGated_i(ramGated), .addr_i(addr),
        .data_o(data1), .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn),
        .ramReady_o(ready1)
    );

    typedef struct {
        int               port;
        logic [INDEX-1:0] waddr;
        logic [WIDTH-1:0] wdata;
        logic [INDEX-1:0] raddr;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wrEn = '0;
        for (int w = 0; w < NWR; w++) begin
            addrWr[w] = '0;
            dataWr[w] = '0;
        end
    endtask

    // Releases reset and returns the number of edges (from the first edge
    // that samples reset high) until ramReady_o is seen high.
    task automatic wait_ready(output int edges);
        edges = 0;
        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ready0) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        int edges;
        int bad;
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want;

        vecs[0] = '{0, 7'h01, 32'hDEADBEEF, 7'h01, 32'hDEADBEEF};
        vecs[1] = '{7, 7'h7F, 32'h12345678, 7'h7F, 32'h12345678};
        vecs[2] = '{3, 7'h01, 32'h00000042, 7'h01, 32'h00000042};
        vecs[3] = '{5, 7'h20, 32'hFFFFFFFF, 7'h7F, 32'h12345678};
        vecs[4] = '{1, 7'h00, 32'h00000001, 7'h20, 32'hFFFFFFFF};
        vecs[5] = '{6, 7'h40, 32'hA5A5A5A5, 7'h41, 32'h00000000};
        vecs[6] = '{2, 7'h40, 32'h00000000, 7'h40, 32'h00000000};
        vecs[7] = '{4, 7'h00, 32'h80000000, 7'h00, 32'h80000000};

        reset          = 1'b0;
        writePortGated = '0;
        readPortGated  = '0;
        ramGated       = 1'b0;
        idle();
        for (int p = 0; p < NRD; p++) addr[p] = '0;

        // Reset state
        tick();
        tick();
        readPortGated[0] = 1'b1;
        #1;
        chk("reset_ready_zero", {63'd0, ready0}, 64'd0);
        chk("reset_ready_seq", {63'd0, ready1}, 64'd0);
        chk("reset_gated_read", {32'd0, data0[0]}, 64'd0);
        readPortGated[0] = 1'b0;

        // Test 1: ready timing and ZERO contents
        wait_ready(edges);
        chk("init_latency", edges, 17);
        chk("seq_ready", {63'd0, ready1}, 64'd1);
        for (int i = 0; i < DEPTH; i++) gold[i] = '0;
        for (int p = 0; p < NRD; p++) addr[p] = INDEX'($urandom_range(0, DEPTH - 1));
        #1;
        for (int p = 0; p < NRD; p++) chk($sformatf("zero_init_port%0d", p), {32'd0, data0[p]}, 64'd0);

        // Test 2: SEQ mode contents
        addr[0] = 7'h7F;
        addr[1] = 7'h00;
        #1;
        chk("seq_addr7f", {32'd0, data1[0]}, 64'h84);
        chk("seq_addr00", {32'd0, data1[1]}, 64'h05);

        // Table-driven single-port writes with read-back
        for (int i = 0; i < 8; i++) begin
            idle();
            wrEn[vecs[i].port]   = 1'b1;
            addrWr[vecs[i].port] = vecs[i].waddr;
            dataWr[vecs[i].port] = vecs[i].wdata;
            tick();
            gold[vecs[i].waddr] = vecs[i].wdata;
            idle();
            addr[2] = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d", i), {32'd0, data0[2]}, {32'd0, vecs[i].exp});
        end

        // Test 4: same-address collision, plus no bypass in the write cycle
        idle();
        wrEn[2] = 1'b1; addrWr[2] = 7'h10; dataWr[2] = 32'h0000AAAA;
        wrEn[6] = 1'b1; addrWr[6] = 7'h10; dataWr[6] = 32'h00005555;
        addr[3] = 7'h10;
        #1;
        chk("no_bypass", {32'd0, data0[3]}, 64'd0);
        tick();
        idle();
        #1;
        chk("collision_high_wins", {32'd0, data0[3]}, 64'h5555);
        gold[7'h10] = 32'h00005555;

        // Test 5: write-port gating
        writePortGated = 8'h01;
        wrEn[0] = 1'b1; addrWr[0] = 7'h03; dataWr[0] = 32'h00001234;
        tick();
        idle();
        writePortGated = '0;
        addr[3] = 7'h03;
        #1;
        chk("wr_port_gated", {32'd0, data0[3]}, {32'd0, gold[3]});

        // Read-port gating
        readPortGated[4] = 1'b1;
        addr[4] = 7'h10;
        addr[5] = 7'h10;
        #1;
        chk("rd_port_gated", {32'd0, data0[4]}, 64'd0);
        chk("rd_port_neighbour", {32'd0, data0[5]}, 64'h5555);
        readPortGated = '0;

        // Whole-array gating
        ramGated = 1'b1;
        wrEn[1] = 1'b1; addrWr[1] = 7'h10; dataWr[1] = 32'h0000BEEF;
        tick();
        idle();
        bad = 0;
        for (int p = 0; p < NRD; p++) if (data0[p] !== '0) bad++;
        chk("ram_gated_reads", bad, 0);
        ramGated = 1'b0;
        addr[5] = 7'h10;
        #1;
        chk("ram_gated_intact", {32'd0, data0[5]}, 64'h5555);

        // Test 3: random traffic against the golden array
        bad = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int w = 0; w < NWR; w++) begin
                wrEn[w]   = 1'($urandom_range(0, 1));
                addrWr[w] = INDEX'($urandom_range(0, DEPTH - 1));
                dataWr[w] = $urandom;
            end
            for (int p = 0; p < NRD; p++) addr[p] = INDEX'($urandom_range(0, DEPTH - 1));
            #1;
            for (int p = 0; p < NRD; p++) begin
                if (data0[p] !== gold[addr[p]]) begin
                    got  = data0[p];
                    want = gold[addr[p]];
                    bad++;
                end
            end
            if (bad == 1) begin
                chk($sformatf("random_cycle%0d", c), {32'd0, got}, {32'd0, want});
                bad++;
            end
            for (int w = 0; w < NWR; w++) if (wrEn[w]) gold[addrWr[w]] = dataWr[w];
            tick();
        end
        if (bad == 0) chk("random_traffic", 64'd0, {32'd0, bad});
        idle();

        // Test 6: reset mid-INIT restarts full initialisation
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int n = 0; n < 8; n++) tick();
        chk("mid_init_not_ready", {63'd0, ready0}, 64'd0);
        reset = 1'b0;
        tick();
        wait_ready(edges);
        chk("reinit_latency", edges, 17);
        for (int b = 0; b < DEPTH / NRD; b++) begin
            int bz;
            int bs;
            bz = 0;
            bs = 0;
            for (int p = 0; p < NRD; p++) addr[p] = INDEX'(b * NRD + p);
            #1;
            for (int p = 0; p < NRD; p++) begin
                if (data0[p] !== '0) bz++;
                if (data1[p] !== WIDTH'(5 + b * NRD + p)) bs++;
            end
            chk($sformatf("reinit_zero_blk%0d", b), bz, 0);
            chk($sformatf("reinit_seq_blk%0d", b), bs, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
